// File: rtl/am_err_stats.sv
// Error-statistics collector for an 8x8 approximate multiplier: compares each z_apx against the
// exact product and accumulates sum, max and count of error distances over a run of SAMPLES.
module am_err_stats #(
    parameter int unsigned SAMPLES = 65536,
    parameter int unsigned ED_W    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      x,
    input  logic [7:0]      y,
    input  logic [15:0]     z_apx,
    output logic            busy,
    output logic            done,
    output logic [ED_W-1:0] sum_ed,
    output logic [15:0]     max_ed,
    output logic [16:0]     err_cnt,
    output logic [16:0]     smp_cnt
);

    localparam logic [16:0] SampTot = 17'(SAMPLES);
    localparam logic [16:0] LastIdx = 17'(SAMPLES - 1);

    // One spare bit above the wider of the addends catches overflow before saturating.
    localparam int unsigned SumW = ((ED_W > 16) ? ED_W : 16) + 1;
    localparam logic [SumW-1:0] SumMax = SumW'({ED_W{1'b1}});

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic            clear;
    logic            accept;
    logic [15:0]     prod;

    logic            s1_valid_q;
    logic [15:0]     p_q;
    logic [15:0]     z_q;

    logic [15:0]     ed;
    logic [SumW-1:0] sum_wide;
    logic [ED_W-1:0] sum_d, sum_q;
    logic [15:0]     max_d, max_q;
    logic [16:0]     err_d, err_q;
    logic [16:0]     smp_q;

    assign in_ready = (state_q == StRun) && (smp_q < SampTot);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == StRun) || (state_q == StDrain);
    assign done     = (state_q == StDone);
    assign prod     = 16'(x) * 16'(y);

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    clear   = 1'b1;
                end
            end
            StRun: begin
                if (accept && (smp_q == LastIdx)) begin
                    state_d = StDrain;
                end
            end
            // Stage 2 retires the final sample on the edge leaving this state.
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ed       = (p_q >= z_q) ? (p_q - z_q) : (z_q - p_q);
        sum_wide = SumW'(sum_q) + SumW'(ed);
        sum_d    = (sum_wide > SumMax) ? {ED_W{1'b1}} : sum_wide[ED_W-1:0];
        max_d    = (ed > max_q) ? ed : max_q;
        err_d    = (ed != 16'd0) ? (err_q + 17'd1) : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            p_q        <= 16'd0;
            z_q        <= 16'd0;
            smp_q      <= 17'd0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                p_q <= prod;
                z_q <= z_apx;
            end
            if (clear) begin
                smp_q <= 17'd0;
            end else if (accept) begin
                smp_q <= smp_q + 17'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            max_q <= 16'd0;
            err_q <= 17'd0;
        end else if (clear) begin
            sum_q <= '0;
            max_q <= 16'd0;
            err_q <= 17'd0;
        end else if (s1_valid_q) begin
            sum_q <= sum_d;
            max_q <= max_d;
            err_q <= err_d;
        end
    end

    assign sum_ed  = sum_q;
    assign max_ed  = max_q;
    assign err_cnt = err_q;
    assign smp_cnt = smp_q;

endmodule
